instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Program loader that writes the instruction memory read by the single-cycle core's fetch stage.
- Receives a byte stream on a valid/ready handshake, packs bytes little-endian into 32-bit words, and issues one-cycle word writes to the instruction memory.
- Holds the core in reset (`cpu_hold`) until a load completes and its checksum passes.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- WORDS, 256, maximum program length in words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  core held in reset while high.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum (sticky).
- err  out  1  last load failed (sticky).
- word_count  out  16  length field of the current or last load.

Behaviour:
- Transfer rule: a byte transfers on a rising edge where byte_valid & byte_ready.
  - byte_valid may drop at any time; no state advances without a transfer.
  - byte_data is ignored without byte_valid.
- Frame format: LEN_LO, LEN_HI (16-bit N, little-endian), then 4·N data bytes (LSB first per word), then one CHK byte.
  - CHK = XOR of all data bytes. Length bytes are not included.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR.
- Reset (rst=0 at an edge): state=IDLE; all counters, word_count, mem_addr, mem_wdata and the checksum accumulator = 0; byte_ready=0, mem_we=0, busy=0, done=0, err=0, cpu_hold=1.
  - Reset mid-load aborts the load. Memory contents already written are not restored.
- IDLE/DONE/ERR + start → LEN_LO. This clears done, err, the checksum accumulator and the word index, and sets cpu_hold=1.
- LEN_LO on transfer → LEN_HI.
- LEN_HI on transfer:
  - N==0 or N>WORDS → ERR.
  - otherwise → DATA, with the byte index at 0.
- DATA on transfer: the byte shifts into its lane (byte index b → bits 8b+7:8b) and XORs into the accumulator.
  - On the 4th byte → WRITE.
- WRITE (exactly 1 cycle): mem_we=1, mem_addr=word index, mem_wdata=assembled word; byte_ready=0.
  - Next state: if word index == N−1 → CHK; else increment the word index → DATA.
- CHK on transfer: byte == accumulator → DONE; else → ERR.
- Output decode:
  - byte_ready = 1 only in LEN_LO, LEN_HI, DATA, CHK.
  - busy = 1 in LEN_LO through CHK.
  - cpu_hold = 0 only in DONE.
  - done = 1 in DONE; err = 1 in ERR.
- start is ignored while busy. start coincident with reset: reset wins.
- Throughput: 5 cycles per word at full rate (4 transfers + WRITE).
- mem_addr and mem_wdata keep their last values outside WRITE; consumers qualify them with mem_we.
- Word index width is ADDR_W. N ≤ WORDS guarantees no wrap.

Decomposition:
- Package loader_pkg: state enum, FRAME_HDR_BYTES=2, BYTES_PER_WORD=4.
- Optional sub-module loader_word_packer: byte shift-in, lane index, XOR accumulator, word_full flag. The top keeps the FSM and memory-write logic.

Test Plan:
- Good load, WORDS=256. Bytes 02 00 78 56 34 12 EF BE AD DE 2A, byte_valid held high.
  - Writes addr0=0x12345678 and addr1=0xDEADBEEF, one mem_we cycle each.
  - Then done=1, cpu_hold=0, word_count=2.
- Same frame with CHK=0x2B → both writes still occur; err=1, done=0, cpu_hold stays 1.
- Length checks:
  - Length 00 00 → err=1 immediately after LEN_HI; no mem_we ever.
  - Length 01 01 (257 > WORDS) → err=1; no mem_we ever.
- Good frame with byte_valid toggling randomly and gaps up to 10 cycles → identical writes and done=1; byte_ready=0 during every WRITE cycle.
- Reset and start handling:
  - rst=0 after 6 data bytes → next cycle: IDLE, busy=0, cpu_hold=1, byte_ready=0.
  - A fresh good load then succeeds.
  - start pulsed mid-load is ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   state_e          loader FSM state encoding
//   FRAME_HDR_BYTES  length-field bytes ahead of the payload
//   BYTES_PER_WORD   payload bytes packed into one memory word
//   LANE_W           width of the byte-lane index inside a word
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int BYTES_PER_WORD  = 4;
    localparam int LANE_W          = $clog2(BYTES_PER_WORD);

    // States in which the loader owns the stream and the core stays parked.
    function automatic logic is_busy(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) ||
               (s == ST_WRITE)  || (s == ST_CHK);
    endfunction

    // States that take a byte from the stream.
    function automatic logic takes_byte(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) ||
               (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs payload bytes little-endian into a 32-bit word and keeps the
// running XOR checksum of every payload byte.
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   clr_i        restart: lane index, word and checksum back to zero
//   shift_i      accept data_i into the current lane
//   data_i       payload byte
//   word_o       assembled word (registered)
//   word_next_o  assembled word including data_i in the current lane
//   acc_o        XOR of all bytes shifted in since the last clear
//   word_full_o  the byte being shifted in completes the word
module loader_word_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic [31:0] word_next_o,
    output logic [7:0]  acc_o,
    output logic        word_full_o
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q;
    logic [31:0]       word_q;
    logic [7:0]        acc_q;

    always_comb begin
        word_next_o = word_q;
        word_next_o[{lane_q, 3'b000} +: 8] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lane_q <= '0;
            word_q <= '0;
            acc_q  <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            word_q <= '0;
            acc_q  <= '0;
        end else if (shift_i) begin
            word_q <= word_next_o;
            acc_q  <= acc_q ^ data_i;
            // Lane wraps back to 0 after the last byte of a word.
            lane_q <= lane_q + 1'b1;
        end
    end

    assign word_o      = word_q;
    assign acc_o       = acc_q;
    assign word_full_o = shift_i && (lane_q == LAST_LANE);

endmodule

// File: rtl/instr_loader.sv
// Program loader for the instruction memory of the single-cycle core.
// Accepts a LEN_LO, LEN_HI, 4*N payload bytes, CHK frame on a valid/ready
// byte stream, writes each packed word to memory in a one-cycle WRITE
// state and releases the core only after the checksum matches.
//   clk_i         system clock
//   rst_ni        synchronous active-low reset
//   start_i       begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid_i  byte_data_i holds a valid byte
//   byte_data_i   stream byte
//   byte_ready_o  loader accepts a byte this cycle
//   mem_we_o      instruction-memory write strobe, one cycle per word
//   mem_addr_o    word address of the write
//   mem_wdata_o   word to write
//   cpu_hold_o    core held in reset while high
//   busy_o        load in progress
//   done_o        last load completed with a good checksum
//   err_o         last load failed
//   word_count_o  length field of the current or last load
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | after reset, waiting for start
// LEN_LO   | waiting for low byte of the word count
// LEN_HI   | waiting for high byte; range-check the count
// DATA     | shifting payload bytes into the current word
// WRITE    | one-cycle memory write of the assembled word
// CHK      | waiting for the checksum byte
// DONE     | load good, core released
// ERR      | bad length or checksum, core kept in reset
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORDS  = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       word_count_o
);

    localparam logic [16:0] WORDS_L = 17'(WORDS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       word_count_q;
    logic              byte_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              xfer;
    logic              start_ok;
    logic              shift;
    logic              word_full;
    logic [15:0]       n_len;
    logic              len_bad;
    logic              last_word;
    logic [ADDR_W-1:0] last_idx;
    logic [31:0]       word_cur;
    logic [31:0]       word_next;
    logic [7:0]        acc;

    // byte_ready_q is decoded from the registered state, so it is a
    // faithful view of whether the current state consumes bytes.
    assign xfer     = byte_valid_i && byte_ready_q;
    assign start_ok = start_i && ((state_q == ST_IDLE) ||
                                  (state_q == ST_DONE) ||
                                  (state_q == ST_ERR));
    assign shift    = xfer && (state_q == ST_DATA);

    assign n_len     = {byte_data_i, len_lo_q};
    assign len_bad   = (n_len == 16'd0) || ({1'b0, n_len} > WORDS_L);
    // N <= WORDS <= 2^ADDR_W, so N-1 always fits the word index.
    assign last_idx  = ADDR_W'(word_count_q - 16'd1);
    assign last_word = (word_idx_q == last_idx);

    loader_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (start_ok),
        .shift_i     (shift),
        .data_i      (byte_data_i),
        .word_o      (word_cur),
        .word_next_o (word_next),
        .acc_o       (acc),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (xfer) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) state_d = len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = last_word ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (xfer) state_d = (byte_data_i == acc) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            word_idx_q   <= '0;
            len_lo_q     <= '0;
            word_count_q <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Outputs decoded from the next state so they line up with it.
            byte_ready_q <= takes_byte(state_d);
            busy_q       <= is_busy(state_d);
            cpu_hold_q   <= (state_d != ST_DONE);
            done_q       <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERR);
            mem_we_q     <= (state_d == ST_WRITE);

            if (start_ok) begin
                word_idx_q <= '0;
            end else if (state_q == ST_WRITE && state_d == ST_DATA) begin
                word_idx_q <= word_idx_q + 1'b1;
            end

            if (xfer && state_q == ST_LEN_LO) begin
                len_lo_q <= byte_data_i;
            end
            if (xfer && state_q == ST_LEN_HI) begin
                word_count_q <= n_len;
            end

            // The 4th byte is still on the bus, so take the merged word.
            if (word_full) begin
                mem_addr_q  <= word_idx_q;
                mem_wdata_q <= word_next;
            end
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign word_count_o = word_count_q;

    // The registered word is only observed through word_next.
    logic unused_word;
    assign unused_word = ^word_cur;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: good load, bad checksum, bad lengths,
// stalled stream, reset mid-load and start ignored while busy.
module tb_instr_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int tests = 0;
    int fails = 0;

    int          wr_n = 0;
    int          wr_viol = 0;
    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    logic [7:0] frm [0:10];

    instr_loader #(.ADDR_W(8), .WORDS(256)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .cpu_hold_o   (cpu_hold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .word_count_o (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: one entry per cycle with mem_we high.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            if (byte_ready) wr_viol = wr_viol + 1;
            wr_n = wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        guard = 0;
        while (!byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] chkb, input int max_gap, input int pulse_at);
        logic [7:0] b;
        for (int i = 0; i < 11; i++) begin
            b = (i == 10) ? chkb : frm[i];
            if (i == pulse_at) pulse_start();
            send_byte(b, int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic check_good_writes(input string tag, input int base);
        chk({tag, "_nwr"},   32'(wr_n - base), 32'd2);
        chk({tag, "_addr0"}, {24'd0, wr_addr[base]},     32'd0);
        chk({tag, "_data0"}, wr_data[base],              32'h1234_5678);
        chk({tag, "_addr1"}, {24'd0, wr_addr[base + 1]}, 32'd1);
        chk({tag, "_data1"}, wr_data[base + 1],          32'hDEAD_BEEF);
    endtask

    initial begin
        int base;
        frm[0] = 8'h02; frm[1] = 8'h00;
        frm[2] = 8'h78; frm[3] = 8'h56; frm[4] = 8'h34; frm[5] = 8'h12;
        frm[6] = 8'hEF; frm[7] = 8'hBE; frm[8] = 8'hAD; frm[9] = 8'hDE;
        frm[10] = 8'h2A;

        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'd0, byte_ready}, 32'd0);
        chk("rst_we",     {31'd0, mem_we},     32'd0);
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_done",   {31'd0, done},       32'd0);
        chk("rst_err",    {31'd0, err},        32'd0);
        chk("rst_hold",   {31'd0, cpu_hold},   32'd1);
        chk("rst_wcount", {16'd0, word_count}, 32'd0);
        chk("rst_addr",   {24'd0, mem_addr},   32'd0);
        chk("rst_wdata",  mem_wdata,           32'd0);
        // start with reset asserted: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good load at full rate
        base = wr_n;
        pulse_start();
        chk("g_busy",  {31'd0, busy},       32'd1);
        chk("g_ready", {31'd0, byte_ready}, 32'd1);
        send_frame(8'h2A, 0, -1);
        check_good_writes("g", base);
        chk("g_done",   {31'd0, done},       32'd1);
        chk("g_err",    {31'd0, err},        32'd0);
        chk("g_hold",   {31'd0, cpu_hold},   32'd0);
        chk("g_busy2",  {31'd0, busy},       32'd0);
        chk("g_wcount", {16'd0, word_count}, 32'd2);

        // Bad checksum
        base = wr_n;
        pulse_start();
        chk("c_done_clr", {31'd0, done}, 32'd0);
        send_frame(8'h2B, 0, -1);
        check_good_writes("c", base);
        chk("c_err",  {31'd0, err},      32'd1);
        chk("c_done", {31'd0, done},     32'd0);
        chk("c_hold", {31'd0, cpu_hold}, 32'd1);

        // Length 0
        base = wr_n;
        pulse_start();
        chk("z_err_clr", {31'd0, err}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("z_err",  {31'd0, err},  32'd1);
        chk("z_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("z_nwr",    32'(wr_n - base),    32'd0);
        chk("z_wcount", {16'd0, word_count}, 32'd0);

        // Length 257 > WORDS
        base = wr_n;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("o_err",   {31'd0, err},        32'd1);
        chk("o_ready", {31'd0, byte_ready}, 32'd0);
        repeat (6) @(negedge clk);
        chk("o_nwr",    32'(wr_n - base),    32'd0);
        chk("o_wcount", {16'd0, word_count}, 32'd257);

        // Stalled stream with random gaps
        base = wr_n;
        wr_viol = 0;
        pulse_start();
        send_frame(8'h2A, 10, -1);
        check_good_writes("r", base);
        chk("r_done",   {31'd0, done},     32'd1);
        chk("r_hold",   {31'd0, cpu_hold}, 32'd0);
        chk("r_wrready", 32'(wr_viol),     32'd0);

        // Reset after 6 data bytes
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(frm[i], 0);
        chk("m_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("m_busy",  {31'd0, busy},       32'd0);
        chk("m_hold",  {31'd0, cpu_hold},   32'd1);
        chk("m_ready", {31'd0, byte_ready}, 32'd0);
        chk("m_done",  {31'd0, done},       32'd0);
        @(negedge clk);

        // Fresh load with start pulsed mid-payload
        base = wr_n;
        pulse_start();
        send_frame(8'h2A, 2, 5);
        check_good_writes("s", base);
        chk("s_done",   {31'd0, done},       32'd1);
        chk("s_err",    {31'd0, err},        32'd0);
        chk("s_wcount", {16'd0, word_count}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
